// File: rtl/hud_defs_pkg.sv
// Shared constants and helpers for the HUD number displays.
// Glyph geometry, the number_count field layout and BCD helpers.
package hud_defs_pkg;

  localparam int unsigned PixelDisplayBit = 9;
  localparam int unsigned GlyphWLog2      = 3;
  localparam int unsigned GlyphHLog2      = 4;
  localparam logic [3:0]  BCD_MAX         = 4'd9;

  // Address into the shared numbers ROM: glyph row in the high nibble.
  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
  } number_count_t;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : nib;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of a chained up/down counter.
// carry_o doubles as borrow when counting down; it only fires when step_i is set.
module bcd_digit_cell
  import hud_defs_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       step_i,
  input  logic       down_i,
  output logic [3:0] digit_o,
  output logic       carry_o
);

  logic [3:0] digit_d, digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clear_i) begin
      digit_d = 4'd0;
    end else if (load_i) begin
      digit_d = bcd_clamp(load_val_i);
    end else if (step_i) begin
      if (down_i) begin
        digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
      end else begin
        digit_d = (digit_q >= BCD_MAX) ? 4'd0 : digit_q + 4'd1;
      end
    end
  end

  always_comb begin
    carry_o = step_i & (down_i ? (digit_q == 4'd0) : (digit_q == BCD_MAX));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/hud_bcd_counter_display.sv
// N-digit BCD up/down counter with an on-screen region mapper feeding the numbers ROM.
// Display outputs are zero outside the region so several instances can be OR-combined.
module hud_bcd_counter_display
  import hud_defs_pkg::*;
#(
  parameter int unsigned DIGITS            = 3,
  parameter int unsigned PIXEL_DISPLAY_BIT = PixelDisplayBit,
  parameter int unsigned COUNT_DOWN        = 0,
  parameter int unsigned SATURATE          = 1,
  parameter int unsigned X_POS             = 16,
  parameter int unsigned Y_POS             = 8,
  parameter int unsigned DIGIT_W_LOG2      = GlyphWLog2,
  parameter int unsigned DIGIT_H_LOG2      = GlyphHLog2
) (
  input  logic                         clock_25,
  input  logic                         reset,
  input  logic                         sync_reset,
  input  logic                         en_count,
  input  logic                         count_tik,
  input  logic                         load,
  input  logic [4*DIGITS-1:0]          load_value,
  input  logic [PIXEL_DISPLAY_BIT:0]   X,
  input  logic [PIXEL_DISPLAY_BIT:0]   Y,
  output logic [4*DIGITS-1:0]          bcd_value,
  output logic                         limit_flag,
  output logic                         wrap_pulse,
  output logic                         en_region,
  output logic [3:0]                   selected_number,
  output logic [7:0]                   number_count
);

  if (DIGITS < 1 || DIGITS > 8 || DIGIT_W_LOG2 > 4 || DIGIT_H_LOG2 > 4) begin : g_bad_param
    $error("hud_bcd_counter_display: unsupported DIGITS/DIGIT_W_LOG2/DIGIT_H_LOG2");
  end

  localparam int unsigned RegionW = DIGITS << DIGIT_W_LOG2;
  localparam int unsigned RegionH = 1 << DIGIT_H_LOG2;
  localparam int unsigned ColMask = (1 << DIGIT_W_LOG2) - 1;
  localparam int unsigned RowMask = (1 << DIGIT_H_LOG2) - 1;
  localparam logic [4*DIGITS-1:0] AllNines = {DIGITS{BCD_MAX}};
  localparam logic CountDown = (COUNT_DOWN != 0);
  localparam logic Saturate  = (SATURATE != 0);

  // ---------------- counter ----------------
  logic [DIGITS:0]   step;
  logic [DIGITS-1:0] carry;
  logic              at_limit;
  logic              tik_ok;
  logic              wrap_event;
  logic              wrap_d, wrap_q;

  always_comb begin
    at_limit   = CountDown ? (bcd_value == '0) : (bcd_value == AllNines);
    // load and sync_reset win over a coincident tik
    tik_ok     = count_tik & en_count & ~load & ~sync_reset;
    wrap_event = tik_ok & at_limit & ~Saturate;
    step[0]    = tik_ok & ~(Saturate & at_limit);
    wrap_d     = sync_reset ? 1'b0 : wrap_event;
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk_i      (clock_25),
      .rst_ni     (reset),
      .clear_i    (sync_reset),
      .load_i     (load & ~sync_reset),
      .load_val_i (load_value[4*g +: 4]),
      .step_i     (step[g]),
      .down_i     (CountDown),
      .digit_o    (bcd_value[4*g +: 4]),
      .carry_o    (carry[g])
    );
    assign step[g+1] = carry[g];
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign limit_flag = at_limit;
  assign wrap_pulse = wrap_q;

  // ---------------- region mapper ----------------
  logic [31:0]   x_ext, y_ext, dx, dy, digit_idx;
  logic          in_region;
  logic [3:0]    sel_d;
  number_count_t nc_d;
  logic          en_q;
  logic [3:0]    sel_q;
  number_count_t nc_q;

  always_comb begin
    x_ext     = 32'(X);
    y_ext     = 32'(Y);
    in_region = (x_ext >= X_POS) && (x_ext < X_POS + RegionW) &&
                (y_ext >= Y_POS) && (y_ext < Y_POS + RegionH);
    dx        = x_ext - X_POS;
    dy        = y_ext - Y_POS;
    digit_idx = dx >> DIGIT_W_LOG2;
    sel_d     = 4'd0;
    nc_d      = '0;
    if (in_region) begin
      // index 0 is the leftmost (most significant) digit
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (digit_idx == i) sel_d = bcd_value[4*(DIGITS-1-i) +: 4];
      end
      nc_d.col = 4'(dx & ColMask);
      nc_d.row = 4'(dy & RowMask);
    end
  end

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      en_q  <= 1'b0;
      sel_q <= 4'd0;
      nc_q  <= '0;
    end else begin
      en_q  <= in_region;
      sel_q <= sel_d;
      nc_q  <= nc_d;
    end
  end

  assign en_region       = en_q;
  assign selected_number = sel_q;
  assign number_count    = nc_q;

endmodule

// File: doc/hud_bcd_counter_display.md
Name: hud_bcd_counter_display

Overview:
Parametrised successor to the fixed time/score controllers. Holds an N-digit BCD counter that counts up or down on a tick, and maps the VGA X/Y position onto a screen region. For the pixel under the scan it outputs the digit value and the glyph row/column to the shared numbers ROM. Its outputs are forced to zero outside its region, so several instances can be OR-combined into one ROM.

Parameters:
DIGITS, 3, number of BCD digits (1..8)
PIXEL_DISPLAY_BIT, 9, MSB index of X/Y
COUNT_DOWN, 0, 0 = count up on tick, 1 = count down
SATURATE, 1, 1 = hold at limit, 0 = wrap
X_POS, 16, left pixel column of the region
Y_POS, 8, top pixel row of the region
DIGIT_W_LOG2, 3, glyph width = 2^DIGIT_W_LOG2 (8)
DIGIT_H_LOG2, 4, glyph height = 2^DIGIT_H_LOG2 (16)

Ports:
clock_25  in  1  system clock (25 MHz pixel clock)
reset  in  1  asynchronous, active-low reset
sync_reset  in  1  synchronous clear, active-high (new game)
en_count  in  1  counting enable (game started)
count_tik  in  1  one-cycle count pulse
load  in  1  synchronous load strobe
load_value  in  4*DIGITS  BCD preset value, MSD in the top nibble
X  in  PIXEL_DISPLAY_BIT+1  current pixel column
Y  in  PIXEL_DISPLAY_BIT+1  current pixel row
bcd_value  out  4*DIGITS  current counter value, MSD in the top nibble
limit_flag  out  1  high while the counter sits at its limit (up: all 9s; down: 0)
wrap_pulse  out  1  one-cycle pulse when the counter wraps (SATURATE=0 only)
en_region  out  1  registered: pixel is inside the region
selected_number  out  4  registered: BCD digit under the pixel, 0 outside the region
number_count  out  8  registered: {glyph_row[3:0], glyph_col[3:0]}, 0 outside the region

Behaviour:
- Reset (reset=0, asynchronous): all outputs and internal registers go to 0. Exception: when COUNT_DOWN=1, limit_flag reflects a zero count, so it reads 1.
- Counter update priority, evaluated per clock: reset > sync_reset > load > (count_tik & en_count).
- sync_reset clears the counter to 0 and clears wrap_pulse.
- load takes load_value when every nibble is ≤ 9. Any nibble > 9 is loaded as 9.
- A count_tik with en_count=0 is ignored. A tik in the same cycle as load or sync_reset is dropped.
- Up count: add 1 to the LSD with full carry ripple across all digits in one cycle (e.g. 099 → 100).
- Down count: subtract 1 with full borrow across all digits (e.g. 100 → 099).
- At the limit, with SATURATE=1: the value holds and wrap_pulse stays 0.
- At the limit, with SATURATE=0: up wraps to 0 and down wraps to all 9s. wrap_pulse is high for exactly the cycle after the wrap.
- limit_flag is combinational from the counter register.
- bcd_value is the counter register itself; it updates the cycle after the event.
- Region: X_POS ≤ X < X_POS + DIGITS·2^DIGIT_W_LOG2 and Y_POS ≤ Y < Y_POS + 2^DIGIT_H_LOG2.
- Inside the region:
  - dx = X − X_POS, dy = Y − Y_POS.
  - digit index = dx >> DIGIT_W_LOG2; index 0 is the MSD (leftmost).
  - glyph_col = dx low DIGIT_W_LOG2 bits, zero-extended to 4 bits.
  - glyph_row = dy low DIGIT_H_LOG2 bits.
- Display pipeline latency is 1 clock: X/Y at cycle n give en_region/selected_number/number_count at n+1. With the numbers ROM's registered read, number_pixel arrives at n+2.
- Outside the region, all three display outputs are 0 (required for the OR-combine).
- The display reads the counter value registered in the same cycle as X/Y sampling. No glitch is permitted between digits; a mid-frame update is allowed.
- Elaboration error (via a generate/$error guard) if DIGIT_W_LOG2 > 4, DIGIT_H_LOG2 > 4, or DIGITS outside 1..8.

Decomposition:
- Shared package/include (hud_defs):
  - glyph size constants;
  - the number_count field layout {row, col};
  - BCD_MAX = 4'd9;
  - the PIXEL_DISPLAY_BIT default.
- Sub-module bcd_digit_cell:
  - one 4-bit digit with inc/dec, carry/borrow in/out, load and clear;
  - DIGITS instances, generated and chained.
- Region mapper and pipeline register stay in the top.

Test Plan:
- Reset, then DIGITS=3, COUNT_DOWN=0: 123 count_tiks with en_count=1 → bcd_value=12'h123; limit_flag=0.
- Load 12'h998, 3 tiks, SATURATE=1 → 999 held; limit_flag=1; wrap_pulse never 1. Same with SATURATE=0 → 999 then 000, with wrap_pulse for exactly one cycle.
- COUNT_DOWN=1: load 12'h100, 1 tik → 12'h099. Then load 0, 1 tik → holds 0 (SATURATE=1) with limit_flag=1.
- In one cycle assert load=1 (12'h555), count_tik=1 and en_count=1 → 555 (tik dropped). Next, sync_reset together with a tik → 000. Tiks with en_count=0 → no change.
- Value 12'h407, X_POS=16, Y_POS=8: X=16,Y=8 → next cycle selected_number=4, number_count=8'h00. X=39,Y=23 → selected_number=7, number_count=8'hF7. X=40 or Y=24 → all display outputs 0, en_region=0.
- Assert reset=0 asynchronously mid-count, between clock edges → bcd_value=0 and display outputs=0 immediately. Release reset, and counting resumes from 0 on the next tik.
